// File: rtl/register_file.sv
// 32 x 32-bit RISC-V integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, writes frozen by finish_flag.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] Read1,
    input  logic [ADDR_WIDTH-1:0] Read2,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  finish_flag,
    output logic [DATA_WIDTH-1:0] Data1,
    output logic [DATA_WIDTH-1:0] Data2
);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign wr_en = RegWrite & ~finish_flag;

    // Each register is its own flop bank with an async clear, so the whole
    // file empties the moment reset_n falls. An X on wr_en evaluates the
    // if-condition as false, leaving the register untouched.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign regs[gi] = '0;
        end else begin : g_flop
            logic [DATA_WIDTH-1:0] q_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_reg <= '0;
                end else if (wr_en && (RD == ADDR_WIDTH'(gi))) begin
                    q_reg <= WriteData;
                end
            end

            assign regs[gi] = q_reg;
        end
    end

    // No write-to-read bypass: a same-cycle write shows up after the edge.
    assign Data1 = (Read1 == '0) ? '0 : regs[Read1];
    assign Data2 = (Read2 == '0) ? '0 : regs[Read2];

endmodule

// File: tb/tb_register_file.sv
// Directed test of register_file: reset, write/read, x0, read-during-write,
// X write enable, freeze, boundary index and asynchronous reset.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] Read1, Read2, RD;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic          finish_flag;
    logic [DW-1:0] Data1, Data2;

    int checks = 0;
    int errors = 0;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .Read1       (Read1),
        .Read2       (Read2),
        .RD          (RD),
        .WriteData   (WriteData),
        .RegWrite    (RegWrite),
        .finish_flag (finish_flag),
        .Data1       (Data1),
        .Data2       (Data2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive a write at the falling edge and hold it for n rising edges.
    task automatic do_write(input logic [AW-1:0] rd, input logic [DW-1:0] wd, input int n);
        @(negedge clock);
        RegWrite  = 1'b1;
        RD        = rd;
        WriteData = wd;
        repeat (n) @(posedge clock);
        @(negedge clock);
        RegWrite  = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        Read1       = 5'd7;
        Read2       = 5'd10;
        RD          = '0;
        WriteData   = '0;
        RegWrite    = 1'b0;
        finish_flag = 1'b0;

        // Reset held for two cycles, then released away from the edge.
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold_d1", Data1, 32'h0000_0000);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset_rel_d1", Data1, 32'h0000_0000);
        check("reset_rel_d2", Data2, 32'h0000_0000);

        // Basic write/read.
        do_write(5'd3, 32'hABCD_EFFF, 5);
        do_write(5'd5, 32'hFBCD_E111, 3);
        Read1 = 5'd3;
        Read2 = 5'd5;
        #1;
        check("basic_r3", Data1, 32'hABCD_EFFF);
        check("basic_r5", Data2, 32'hFBCD_E111);
        Read1 = 5'd7;
        Read2 = 5'd10;
        #1;
        check("unwritten_r7", Data1, 32'h0000_0000);
        check("unwritten_r10", Data2, 32'h0000_0000);

        // x0 ignores writes.
        do_write(5'd0, 32'hFFFF_FFFF, 1);
        Read1 = 5'd0;
        Read2 = 5'd0;
        #1;
        check("x0_d1", Data1, 32'h0000_0000);
        check("x0_d2", Data2, 32'h0000_0000);

        // Read-during-write: old value until the edge, new value after.
        do_write(5'd9, 32'h1111_1111, 1);
        Read1     = 5'd9;
        Read2     = 5'd9;
        RegWrite  = 1'b1;
        RD        = 5'd9;
        WriteData = 32'h2222_2222;
        #1;
        check("rdw_before_d1", Data1, 32'h1111_1111);
        check("rdw_before_d2", Data2, 32'h1111_1111);
        @(posedge clock);
        #1;
        check("rdw_after_d1", Data1, 32'h2222_2222);
        check("rdw_after_d2", Data2, 32'h2222_2222);
        @(negedge clock);
        RegWrite = 1'b0;

        // Unknown write enable must not corrupt the register.
        RegWrite  = 1'bx;
        RD        = 5'd9;
        WriteData = 32'hDEAD_BEEF;
        @(posedge clock);
        @(negedge clock);
        RegWrite  = 1'b0;
        #1;
        check("x_we_r9", Data1, 32'h2222_2222);

        // Freeze: writes blocked, reads still live.
        finish_flag = 1'b1;
        do_write(5'd3, 32'h0000_0000, 3);
        Read1 = 5'd3;
        Read2 = 5'd5;
        #1;
        check("freeze_r3", Data1, 32'hABCD_EFFF);
        check("freeze_r5", Data2, 32'hFBCD_E111);
        finish_flag = 1'b0;

        // Unfrozen writes resume; top index boundary.
        do_write(5'd3, 32'h1234_5678, 1);
        do_write(5'd31, 32'hCAFE_F00D, 1);
        Read1 = 5'd3;
        Read2 = 5'd31;
        #1;
        check("unfreeze_r3", Data1, 32'h1234_5678);
        check("top_r31", Data2, 32'hCAFE_F00D);

        // Asynchronous reset between edges.
        do_write(5'd5, 32'h55AA_55AA, 1);
        Read1 = 5'd31;
        Read2 = 5'd5;
        #1;
        check("pre_areset_r5", Data2, 32'h55AA_55AA);
        #1;
        reset_n = 1'b0;
        #1;
        check("areset_r5", Data2, 32'h0000_0000);
        check("areset_r31", Data1, 32'h0000_0000);
        @(negedge clock);
        reset_n = 1'b1;
        Read1   = 5'd3;
        #1;
        check("post_areset_r3", Data1, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
